// File: rtl/fp32_pkg.sv
// Shared FP32 definitions: field widths, special constants, divider FSM states
// and the operand classification helper used by the arithmetic units.
package fp32_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_DIVIDE,
    S_ROUND,
    S_DONE
  } div_state_e;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  // Denormals classify as zero: the datapaths flush them to signed zero.
  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    if (e == '0)
      return CLS_ZERO;
    if (e == EXP_W'(EXP_MAX))
      return (m == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational unpack of one FP32 operand into sign, exponent, significand
// with hidden bit, and operand class.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0]      op,
  output logic             sign,
  output logic [EXP_W-1:0] expo,
  output logic [MAN_W:0]   sig,
  output fp_class_e        cls
);

  assign sign = op[31];
  assign expo = op[30:23];
  assign sig  = {1'b1, op[22:0]};
  assign cls  = classify(op[30:23], op[22:0]);

endmodule

// File: rtl/fp32_divider_seq.sv
// Sequential FP32 divider: restoring significand division, one quotient bit
// per cycle, round-to-nearest-even, flush-to-zero, valid/ready on both sides.
module fp32_divider_seq
  import fp32_pkg::*;
#(
  parameter int          QBITS = 26,
  parameter logic [31:0] QNAN  = FP_QNAN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        En,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Out,
  output logic        Invalid_Num,
  output logic        Div_By_Zero
);

  div_state_e         state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d, out_q, out_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [25:0]        rem_q, rem_d;
  logic [23:0]        div_q, div_d;
  logic [QBITS-1:0]   quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d, inv_q, inv_d, dbz_q, dbz_d;

  logic               sign_a, sign_b;
  logic [EXP_W-1:0]   exp_a, exp_b;
  logic [MAN_W:0]     sig_a, sig_b;
  fp_class_e          cls_a, cls_b;

  fp32_classify u_cls_a (.op(a_q), .sign(sign_a), .expo(exp_a), .sig(sig_a), .cls(cls_a));
  fp32_classify u_cls_b (.op(b_q), .sign(sign_b), .expo(exp_b), .sig(sig_b), .cls(cls_b));

  logic               res_sign;
  logic [25:0]        rem_sub;
  logic [QBITS-1:0]   norm;
  logic signed [9:0]  exp_n, exp_r;
  logic [24:0]        mant_r;
  logic [22:0]        frac_r;
  logic               guard, sticky, round_up;

  always_comb begin
    res_sign = sign_a ^ sign_b;
    // Remainder stays below twice the divisor, so bit 25 is the borrow.
    rem_sub  = rem_q - {2'b00, div_q};
    norm     = quo_q[QBITS-1] ? quo_q : {quo_q[QBITS-2:0], 1'b0};
    exp_n    = quo_q[QBITS-1] ? exp_q : exp_q - 10'sd1;
    guard    = norm[1];
    sticky   = norm[0] | (rem_q != '0);
    round_up = guard & (sticky | norm[2]);
    mant_r   = {1'b0, norm[QBITS-1:2]} + {24'd0, round_up};
    exp_r    = mant_r[24] ? exp_n + 10'sd1 : exp_n;
    frac_r   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    out_d       = out_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    rem_d       = rem_q;
    div_d       = div_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    inv_d       = inv_q;
    dbz_d       = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        inv_d   = 1'b0;
        dbz_d   = 1'b0;
        state_d = S_DONE;
        if (cls_a == CLS_NAN) begin
          out_d = a_q;
          inv_d = 1'b1;
        end else if (cls_b == CLS_NAN) begin
          out_d = b_q;
          inv_d = 1'b1;
        end else if ((cls_a == CLS_INF && cls_b == CLS_INF) ||
                     (cls_a == CLS_ZERO && cls_b == CLS_ZERO)) begin
          out_d = QNAN;
          inv_d = 1'b1;
        end else if (cls_a == CLS_INF) begin
          out_d = {res_sign, POS_INF[30:0]};
        end else if (cls_b == CLS_INF || cls_a == CLS_ZERO) begin
          out_d = {res_sign, 31'd0};
        end else if (cls_b == CLS_ZERO) begin
          out_d = {res_sign, POS_INF[30:0]};
          dbz_d = 1'b1;
        end else begin
          rem_d   = {2'b00, sig_a};
          div_d   = sig_b;
          quo_d   = '0;
          cnt_d   = '0;
          sign_d  = res_sign;
          exp_d   = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + 10'(BIAS);
          state_d = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        if (!rem_sub[25]) begin
          rem_d = {rem_sub[24:0], 1'b0};
          quo_d = {quo_q[QBITS-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[24:0], 1'b0};
          quo_d = {quo_q[QBITS-2:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(QBITS - 1))
          state_d = S_ROUND;
      end
      S_ROUND: begin
        if (exp_r >= 10'(EXP_MAX))
          out_d = {sign_q, POS_INF[30:0]};
        else if (exp_r <= 10'sd0)
          out_d = {sign_q, 31'd0};
        else
          out_d = {sign_q, exp_r[7:0], frac_r};
        inv_d   = 1'b0;
        dbz_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      out_q       <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      inv_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else if (En) begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_q       <= out_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      inv_q       <= inv_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = rst_n && En && (state_q == S_IDLE);
  assign out_valid   = out_valid_q;
  assign Out         = out_q;
  assign Invalid_Num = inv_q;
  assign Div_By_Zero = dbz_q;

endmodule

// File: tb/tb_fp32_divider_seq.sv
// Directed bench for fp32_divider_seq: wide-integer reference model, per-cycle
// output checker against an expectation queue, latency/stall/enable/reset checks.
module tb_fp32_divider_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        En = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        in_ready, out_valid, Invalid_Num, Div_By_Zero;
  logic [31:0] Out;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] o;
    logic        inv;
    logic        dbz;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fp32_divider_seq dut (
    .clk(clk), .rst_n(rst_n), .En(En), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .Out(Out),
    .Invalid_Num(Invalid_Num), .Div_By_Zero(Div_By_Zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Exact quotient from 60-bit integer division, then normalise and round to nearest even.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] o, output logic inv, output logic dbz);
    int     ea, eb, e, sh;
    bit     a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, up;
    logic   s;
    longint ma, mb, q, r, low, half, mant;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    s = a[31] ^ b[31];
    inv = 1'b0;
    dbz = 1'b0;
    o = '0;
    if (a_nan) begin
      o = a; inv = 1'b1;
    end else if (b_nan) begin
      o = b; inv = 1'b1;
    end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
      o = 32'h7FC00000; inv = 1'b1;
    end else if (a_inf) begin
      o = {s, 8'hFF, 23'd0};
    end else if (b_inf || a_zero) begin
      o = {s, 31'd0};
    end else if (b_zero) begin
      o = {s, 8'hFF, 23'd0}; dbz = 1'b1;
    end else begin
      ma = longint'({1'b1, a[22:0]});
      mb = longint'({1'b1, b[22:0]});
      q = (ma << 36) / mb;
      r = (ma << 36) % mb;
      e = ea - eb + 127;
      if (q >= (longint'(1) << 36)) sh = 13;
      else begin
        sh = 12;
        e--;
      end
      mant = q >> sh;
      low  = q - (mant << sh);
      half = longint'(1) << (sh - 1);
      up = (low > half) || ((low == half) && ((r != 0) || (mant[0] == 1'b1)));
      if (up) mant++;
      if (mant == (longint'(1) << 24)) begin
        mant = mant >> 1;
        e++;
      end
      if (e >= 255) o = {s, 8'hFF, 23'd0};
      else if (e <= 0) o = {s, 31'd0};
      else o = {s, e[7:0], mant[22:0]};
    end
  endfunction

  // Output checker: every cycle the result is presented it must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        check("out", Out, exp_q[0].o);
        check("invalid_num", 32'(Invalid_Num), 32'(exp_q[0].inv));
        check("div_by_zero", 32'(Div_By_Zero), 32'(exp_q[0].dbz));
        check("in_ready_while_done", 32'(in_ready), 32'd0);
        if (out_ready && En) begin
          $display("txn out=%h invalid=%b dbz=%b", Out, Invalid_Num, Div_By_Zero);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic start_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want, input logic want_inv, input logic want_dbz);
    logic [31:0] mo;
    logic        minv, mdbz;
    int          waitc;
    model(a, b, mo, minv, mdbz);
    check({name, "_model"}, mo, want);
    check({name, "_model_flags"}, {30'd0, minv, mdbz}, {30'd0, want_inv, want_dbz});
    @(negedge clk);
    in_valid = 1'b1;
    A = a;
    B = b;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    exp_q.push_back('{o: mo, inv: minv, dbz: mdbz});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] want, input logic want_inv, input logic want_dbz,
                        input int want_lat, input int hold, input int drop_at);
    int          cyc;
    logic [31:0] first_out;
    start_op(name, a, b, want, want_inv, want_dbz);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (drop_at >= 0 && cyc == drop_at) En = 1'b0;
      if (drop_at >= 0 && cyc == drop_at + 3) En = 1'b1;
    end
    check({name, "_latency"}, 32'(cyc), 32'(want_lat));
    first_out = Out;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, "_stall_in_ready"}, 32'(in_ready), 32'd0);
      check({name, "_stall_out"}, Out, first_out);
      check({name, "_stall_valid"}, 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, "_valid_clear"}, 32'(out_valid), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out", Out, 32'd0);
    check("reset_invalid", 32'(Invalid_Num), 32'd0);
    check("reset_dbz", 32'(Div_By_Zero), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    run_op("div_6p8_by_2", 32'h40D9999A, 32'h40000000, 32'h4059999A, 1'b0, 1'b0, 29, 0, -1);
    run_op("one_third",    32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0, 29, 0, -1);
    run_op("neg_6p2_by_2", 32'hC0C66666, 32'h40000000, 32'hC0466666, 1'b0, 1'b0, 29, 0, -1);
    run_op("one_by_one",   32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 29, 0, -1);
    run_op("pi_by_one",    32'h40490FDB, 32'h3F800000, 32'h40490FDB, 1'b0, 1'b0, 29, 0, -1);
    run_op("nan_a",        32'hFFC00000, 32'h40A33333, 32'hFFC00000, 1'b1, 1'b0, 2, 0, -1);
    run_op("nan_b",        32'h3F800000, 32'h7F800001, 32'h7F800001, 1'b1, 1'b0, 2, 0, -1);
    run_op("zero_zero",    32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b0, 2, 0, -1);
    run_op("inf_inf",      32'hFF800000, 32'h7F800000, 32'h7FC00000, 1'b1, 1'b0, 2, 0, -1);
    run_op("div_zero",     32'h40A33333, 32'h00000000, 32'h7F800000, 1'b0, 1'b1, 2, 0, -1);
    run_op("neg_by_negz",  32'hC0000000, 32'h80000000, 32'h7F800000, 1'b0, 1'b1, 2, 0, -1);
    run_op("inf_by_neg",   32'h7F800000, 32'hC0C66666, 32'hFF800000, 1'b0, 1'b0, 2, 0, -1);
    run_op("x_by_inf",     32'h3F800000, 32'hFF800000, 32'h80000000, 1'b0, 1'b0, 2, 0, -1);
    run_op("negzero_by_x", 32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0, 2, 0, -1);
    run_op("denorm_by_x",  32'h00400000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 2, 0, -1);
    run_op("overflow",     32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 1'b0, 29, 0, -1);
    run_op("max_by_half",  32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 1'b0, 1'b0, 29, 0, -1);
    run_op("underflow",    32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 29, 0, -1);
    run_op("min_norm",     32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 1'b0, 29, 0, -1);
    run_op("stall",        32'h40D9999A, 32'h40000000, 32'h4059999A, 1'b0, 1'b0, 29, 5, -1);
    run_op("en_drop",      32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0, 32, 0, 10);

    // Enable low in IDLE: no handshake and nothing starts.
    @(negedge clk);
    En = 1'b0;
    in_valid = 1'b1;
    A = 32'h3F800000;
    B = 32'h40000000;
    #1;
    check("en_low_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    En = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("en_low_no_result", 32'(out_valid), 32'd0);
    check("en_low_still_idle", 32'(in_ready), 32'd1);

    // Reset mid-division discards the operation.
    start_op("reset_mid", 32'h40D9999A, 32'h40000000, 32'h4059999A, 1'b0, 1'b0);
    cyc = 0;
    while (cyc < 10 && !out_valid) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    check("mid_reset_out_valid", 32'(out_valid), 32'd0);
    check("mid_reset_out", Out, 32'd0);
    check("mid_reset_flags", {30'd0, Invalid_Num, Div_By_Zero}, 32'd0);
    check("mid_reset_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_idle", 32'(in_ready), 32'd1);
    repeat (30) @(posedge clk);
    #1;
    check("post_reset_no_stale", 32'(out_valid), 32'd0);
    run_op("after_reset", 32'hC0C66666, 32'h40000000, 32'hC0466666, 1'b0, 1'b0, 29, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp32_divider_seq.md
Name: fp32_divider_seq

Overview:
- Sequential IEEE-754 single-precision divider (Out = A / B), the inverse datapath of the combinational FP32 multiplier in the convolution accelerator.
- Used for normalisation/averaging stages (e.g. dividing accumulated sums by kernel area).
- Iterative restoring mantissa division, one quotient bit per cycle, with valid/ready handshakes on both sides.
- Keeps the multiplier's En gate and Invalid_Num flag semantics.

Parameters:
- QBITS, 26, quotient bits generated per operation (24 significand + 1 normalisation + 1 guard); only 26 is supported.
- QNAN, 32'h7FC00000, canonical quiet NaN returned for invalid operations (0/0, inf/inf).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- En  in  1  global enable; 0 freezes all state, in_ready forced 0
- in_valid  in  1  operands A/B valid
- in_ready  out  1  block can accept operands (state IDLE and En=1)
- A  in  32  dividend, FP32
- B  in  32  divisor, FP32
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  consumer accepts result
- Out  out  32  quotient, FP32
- Invalid_Num  out  1  result is NaN (NaN input, 0/0, inf/inf)
- Div_By_Zero  out  1  finite nonzero / zero

Behaviour:
- Reset (rst_n=0 at clk edge, any state, including mid-division): state IDLE, in_ready=0 during reset, out_valid=0, Out=0, Invalid_Num=0, Div_By_Zero=0, all iteration registers cleared. An in-flight operation is discarded.
- FSM states: IDLE, UNPACK, DIVIDE, ROUND, DONE.
- IDLE: in_ready=1 when En=1. On in_valid&&in_ready, latch A and B and go to UNPACK.
- UNPACK (1 cycle):
  - Classify each operand as zero, denormal (flushed to signed zero), inf, NaN or normal.
  - Special cases go straight to DONE; otherwise load the dividend and divisor significands (1.m), exp = eA - eB + 127, sign = sA^sB, and go to DIVIDE.
- DIVIDE: exactly QBITS cycles.
  - Each cycle: rem = rem - div if non-negative, shift one quotient bit in.
  - Sticky = (final remainder != 0).
- ROUND (1 cycle):
  - If quotient MSB=0, shift left 1 and decrement exp.
  - Round-to-nearest-even using guard and sticky. A mantissa carry-out increments exp.
  - exp >= 255 -> signed inf. exp <= 0 -> signed zero (flush to zero, no denormal output).
  - Go to DONE.
- DONE: out_valid=1 with Out and flags stable. On out_ready=1 go to IDLE, clear out_valid next cycle. The earliest next accept is the cycle after return to IDLE.
- Latency (accept edge to out_valid high):
  - Special cases: 2 cycles.
  - Normal operands: 1+QBITS+1+1 = 29 cycles.
- Special-case priority:
  1. A NaN -> Out=A, Invalid=1.
  2. B NaN -> Out=B, Invalid=1.
  3. inf/inf or 0/0 -> QNAN, Invalid=1.
  4. inf/x -> signed inf.
  5. x/inf -> signed zero.
  6. 0/x -> signed zero.
  7. x/0 -> signed inf, Div_By_Zero=1.
- En=0 in any state: no state, counter or output changes. out_valid stays as-is. Handshakes occurring while En=0 are ignored; in_ready is 0 and out_ready is not sampled.
- Flags are mutually exclusive and valid only while out_valid=1.

Decomposition:
- Shared package fp32_pkg:
  - Field widths and bias constants: EXP_W=8, MAN_W=23, BIAS=127, EXP_MAX=255.
  - QNAN and POS_INF constants.
  - Enum for the FSM states.
  - Operand-class typedef: ZERO, NORM, INF, NAN.
  - Classify function.
- One sub-module, fp32_classify: combinational unpack and classify of one operand, instantiated twice. The multiplier can reuse it.
- Iteration datapath and rounding stay in the top module.

Test Plan:
- A=40D9999A (6.8), B=40000000 -> Out=4059999A, both flags 0, out_valid exactly 29 cycles after accept.
- A=3F800000, B=40400000 (1/3) -> Out=3EAAAAAB (round-to-nearest-even up); A=C0C66666, B=40000000 -> Out=C0466666.
- Specials:
  - A=FFC00000, B=40A33333 -> Out=FFC00000, Invalid=1, 2-cycle latency.
  - 0/0 -> 7FC00000, Invalid=1.
  - 40A33333/00000000 -> 7F800000, Div_By_Zero=1.
  - 7F800000/C0C66666 -> FF800000.
- Overflow and underflow:
  - 7F000000/3E800000 -> 7F800000.
  - 00800000/40000000 -> 00000000 (flushed).
- Handshake, stall and reset:
  - Hold out_ready=0 for 5 cycles: Out stable, in_ready=0 throughout.
  - Drop En for 3 cycles mid-DIVIDE: total latency becomes 32 cycles, same result.
  - rst_n=0 at iteration 10: next cycle out_valid=0, Out=0, state IDLE; a fresh operation afterwards completes correctly.
